reset_seq_sync: RTL and testbench

Parametrised reset synchroniser and sequencer for one clock domain.
- Asserts all channel resets asynchronously on rst.
- Deasserts them synchronously after a synchroniser chain, a minimum hold period, and a staged channel-by-channel release.
- Adds a software-initiated full re-reset and per-channel local reset requests.
- Sits at the top of each clock domain, feeding the reset inputs of datapath and control sub-blocks that must leave reset in a fixed order.

---
 rtl/reset_seq_sync_pkg.sv | 17 +
 rtl/reset_seq_sync_sync_chain.sv | 29 ++
 rtl/reset_seq_sync.sv | 142 ++++++++++++++
 tb/tb_reset_seq_sync.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_sync_pkg.sv
// Shared types and helpers for the reset synchroniser/sequencer.
// Holds the sequencer state encoding and the counter width helper.
package rst_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    function automatic int cnt_width(input int hold, input int gap);
        int m;
        m = (hold > gap) ? hold : gap;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/reset_seq_sync_sync_chain.sv
// Async-set, sync-clear flop chain that turns an async reset
// into one whose falling edge is aligned to clk.
module sync_chain #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    output logic rst_sync
);

    if (DEPTH < 2) begin : g_chk_depth
        $error("sync_chain: DEPTH must be >= 2");
    end

    // Kept as discrete flops so tools never pack them into a shift LUT.
    (* shreg_extract = "no", async_reg = "true" *)
    logic [DEPTH-1:0] q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '1;
        end else begin
            q <= {q[DEPTH-2:0], 1'b0};
        end
    end

    assign rst_sync = q[DEPTH-1];

endmodule

// File: rtl/reset_seq_sync.sv
// Per-domain reset synchroniser and staged channel release sequencer,
// with software re-reset and per-channel local reset requests.
module reset_seq_sync
    import rst_pkg::*;
#(
    parameter int SYNC_DEPTH  = 2,
    parameter int NUM_CH      = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              soft_rst_req,
    input  logic [NUM_CH-1:0] ch_rst_req,
    output logic [NUM_CH-1:0] rst_out,
    output logic              ready,
    output logic              busy
);

    if (SYNC_DEPTH < 2) begin : g_chk_sync
        $error("reset_seq_sync: SYNC_DEPTH must be >= 2");
    end
    if (NUM_CH < 1) begin : g_chk_ch
        $error("reset_seq_sync: NUM_CH must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_chk_hold
        $error("reset_seq_sync: HOLD_CYCLES must be >= 1");
    end
    if (STAGE_GAP < 1) begin : g_chk_gap
        $error("reset_seq_sync: STAGE_GAP must be >= 1");
    end

    localparam int CW = cnt_width(HOLD_CYCLES, STAGE_GAP);
    localparam int IW = $clog2(NUM_CH) + 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [IW-1:0] LAST_CH   = IW'(NUM_CH - 1);

    logic rst_sync;

    sync_chain #(
        .DEPTH (SYNC_DEPTH)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .rst_sync (rst_sync)
    );

    state_t            state;
    state_t            state_n;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_n;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     idx_n;
    logic [NUM_CH-1:0] seq_hold;
    logic [NUM_CH-1:0] hold_n;
    logic [NUM_CH-1:0] ch_req_q;
    logic [NUM_CH-1:0] req_n;

    // Outputs are computed from next-state so they move on the same edge.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        hold_n  = seq_hold;
        req_n   = ch_rst_req;
        if (rst_sync) begin
            state_n = ST_HOLD;
            cnt_n   = '0;
            idx_n   = '0;
            hold_n  = '1;
            req_n   = '0;
        end else if (soft_rst_req) begin
            state_n = ST_HOLD;
            cnt_n   = '0;
            idx_n   = '0;
            hold_n  = '1;
        end else begin
            unique case (state)
                ST_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt_n     = '0;
                        hold_n[0] = 1'b0;
                        idx_n     = IW'(1);
                        state_n   = (NUM_CH == 1) ? ST_RUN : ST_RELEASE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt == GAP_LAST) begin
                        cnt_n = '0;
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (IW'(i) == idx) begin
                                hold_n[i] = 1'b0;
                            end
                        end
                        idx_n = idx + 1'b1;
                        if (idx == LAST_CH) begin
                            state_n = ST_RUN;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    state_n = ST_RUN;
                end
                default: begin
                    state_n = ST_HOLD;
                    cnt_n   = '0;
                    idx_n   = '0;
                    hold_n  = '1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_HOLD;
            cnt      <= '0;
            idx      <= '0;
            seq_hold <= '1;
            ch_req_q <= '0;
            rst_out  <= '1;
            ready    <= 1'b0;
            busy     <= 1'b1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            seq_hold <= hold_n;
            ch_req_q <= req_n;
            rst_out  <= hold_n | req_n;
            ready    <= (state_n == ST_RUN) && (req_n == '0);
            busy     <= (state_n != ST_RUN);
        end
    end

endmodule

// File: tb/tb_reset_seq_sync.sv
// Directed bench for reset_seq_sync: default instance plus a
// single-channel instance with a deeper sync chain and short hold.
module tb_reset_seq_sync;

    logic       clk;
    logic       rst;
    logic       soft_rst_req;
    logic [3:0] ch_rst_req;
    logic [3:0] rst_out;
    logic       ready;
    logic       busy;

    logic       rst1;
    logic       soft1;
    logic [0:0] ch1;
    logic [0:0] rst_out1;
    logic       ready1;
    logic       busy1;

    int n_chk;
    int n_fail;
    int e;
    int e1;

    reset_seq_sync u_dut (
        .clk          (clk),
        .rst          (rst),
        .soft_rst_req (soft_rst_req),
        .ch_rst_req   (ch_rst_req),
        .rst_out      (rst_out),
        .ready        (ready),
        .busy         (busy)
    );

    reset_seq_sync #(
        .SYNC_DEPTH  (3),
        .NUM_CH      (1),
        .HOLD_CYCLES (1),
        .STAGE_GAP   (4)
    ) u_dut1 (
        .clk          (clk),
        .rst          (rst1),
        .soft_rst_req (soft1),
        .ch_rst_req   (ch1),
        .rst_out      (rst_out1),
        .ready        (ready1),
        .busy         (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_to(input int k);
        while (e < k) begin
            @(posedge clk);
            #1;
            e++;
        end
    endtask

    task automatic chk_main(input string tag, input logic [3:0] r,
                            input logic rd, input logic bs);
        chk({tag, ".rst_out"}, rst_out, r);
        chk({tag, ".ready"}, {3'b0, ready}, {3'b0, rd});
        chk({tag, ".busy"}, {3'b0, busy}, {3'b0, bs});
    endtask

    initial begin
        n_chk        = 0;
        n_fail       = 0;
        e            = 0;
        e1           = 0;
        rst          = 1'b0;
        rst1         = 1'b0;
        soft_rst_req = 1'b0;
        ch_rst_req   = 4'b0;
        soft1        = 1'b0;
        ch1          = 1'b0;
        #1;
        rst  = 1'b1;
        rst1 = 1'b1;
        #1;
        chk_main("reset", 4'hF, 1'b0, 1'b1);

        // Test 1: power-on sequence
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        e   = 0;
        run_to(17);
        chk_main("t1.e17", 4'hF, 1'b0, 1'b1);
        run_to(18);
        chk_main("t1.e18", 4'b1110, 1'b0, 1'b1);
        run_to(21);
        chk("t1.e21", rst_out, 4'b1110);
        run_to(22);
        chk("t1.e22", rst_out, 4'b1100);
        run_to(25);
        chk("t1.e25", rst_out, 4'b1100);
        run_to(26);
        chk("t1.e26", rst_out, 4'b1000);
        run_to(29);
        chk_main("t1.e29", 4'b1000, 1'b0, 1'b1);
        run_to(30);
        chk_main("t1.e30", 4'b0000, 1'b1, 1'b0);

        // Test 2: soft re-reset from RUN
        run_to(99);
        soft_rst_req = 1'b1;
        run_to(100);
        soft_rst_req = 1'b0;
        chk_main("t2.e100", 4'hF, 1'b0, 1'b1);
        run_to(115);
        chk("t2.e115", rst_out, 4'hF);
        run_to(116);
        chk("t2.e116", rst_out, 4'b1110);
        run_to(120);
        chk("t2.e120", rst_out, 4'b1100);
        run_to(124);
        chk("t2.e124", rst_out, 4'b1000);
        run_to(127);
        chk_main("t2.e127", 4'b1000, 1'b0, 1'b1);
        run_to(128);
        chk_main("t2.e128", 4'b0000, 1'b1, 1'b0);

        // Test 3: soft re-reset mid-release (offset +50 from test 2)
        run_to(149);
        soft_rst_req = 1'b1;
        run_to(150);
        soft_rst_req = 1'b0;
        run_to(169);
        chk("t3.e169", rst_out, 4'b1110);
        soft_rst_req = 1'b1;
        run_to(170);
        soft_rst_req = 1'b0;
        chk_main("t3.e170", 4'hF, 1'b0, 1'b1);
        run_to(185);
        chk("t3.e185", rst_out, 4'hF);
        run_to(186);
        chk("t3.e186", rst_out, 4'b1110);
        run_to(197);
        chk_main("t3.e197", 4'b1000, 1'b0, 1'b1);
        run_to(198);
        chk_main("t3.e198", 4'b0000, 1'b1, 1'b0);

        // Test 4: local channel reset in RUN
        run_to(199);
        ch_rst_req = 4'b0100;
        chk_main("t4.e199", 4'b0000, 1'b1, 1'b0);
        run_to(200);
        chk_main("t4.e200", 4'b0100, 1'b0, 1'b0);
        run_to(205);
        chk_main("t4.e205", 4'b0100, 1'b0, 1'b0);
        run_to(209);
        ch_rst_req = 4'b0000;
        chk_main("t4.e209", 4'b0100, 1'b0, 1'b0);
        run_to(210);
        chk_main("t4.e210", 4'b0000, 1'b1, 1'b0);

        // Test 5: hard reset mid-release, then full repeat
        rst = 1'b1;
        #1;
        chk_main("t5.async_run", 4'hF, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        e   = 0;
        run_to(22);
        chk("t5.e22", rst_out, 4'b1100);
        run_to(24);
        chk("t5.e24", rst_out, 4'b1100);
        #2;
        rst = 1'b1;
        #1;
        chk_main("t5.async_rel", 4'hF, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        e   = 0;
        run_to(17);
        chk_main("t5.e17", 4'hF, 1'b0, 1'b1);
        run_to(18);
        chk("t5.e18", rst_out, 4'b1110);
        run_to(22);
        chk("t5.e22b", rst_out, 4'b1100);
        run_to(26);
        chk("t5.e26", rst_out, 4'b1000);
        run_to(29);
        chk_main("t5.e29", 4'b1000, 1'b0, 1'b1);
        run_to(30);
        chk_main("t5.e30", 4'b0000, 1'b1, 1'b0);

        // Test 6: single channel, deep sync, hold of one
        chk("t6.reset", {3'b0, rst_out1}, 4'b0001);
        rst1 = 1'b0;
        e1   = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("t6.e3.rst_out", {3'b0, rst_out1}, 4'b0001);
        chk("t6.e3.ready", {3'b0, ready1}, 4'b0000);
        chk("t6.e3.busy", {3'b0, busy1}, 4'b0001);
        @(posedge clk);
        #1;
        chk("t6.e4.rst_out", {3'b0, rst_out1}, 4'b0000);
        chk("t6.e4.ready", {3'b0, ready1}, 4'b0001);
        chk("t6.e4.busy", {3'b0, busy1}, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
